// File: rtl/counter_nb_if.sv
// Control/status bundle for counter_nb: the host side drives the counting
// controls and the terminal value, the counter returns its count and flags.
interface counter_nb_if #(
  parameter int WIDTH    = 32,
  parameter int NUM_LEDS = 3
);
  logic                CE;
  logic                CLR;
  logic                LD;
  logic [WIDTH-1:0]    D;
  logic                UP;
  logic [WIDTH-1:0]    LIMIT;
  logic [WIDTH-1:0]    Q;
  logic                TC;
  logic                OVF;
  logic [NUM_LEDS-1:0] LED;

  modport master (
    output CE, CLR, LD, D, UP, LIMIT,
    input  Q, TC, OVF, LED
  );

  modport slave (
    input  CE, CLR, LD, D, UP, LIMIT,
    output Q, TC, OVF, LED
  );
endinterface

// File: rtl/counter_nb.sv
// Generic-width up/down counter with a clock-enable prescaler, programmable
// terminal value, wrap/saturate behaviour, clear/load, a terminal-count pulse
// and a sticky overflow flag. The LEDs mirror the top bits of the count.
module counter_nb #(
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 1,
  parameter bit SATURATE = 1'b0,
  parameter int NUM_LEDS = 3
) (
  input  logic         CLK,
  input  logic         R_N,
  counter_nb_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic             r_ovf;

  logic             w_step;
  logic [WIDTH-1:0] w_q_next;
  logic             w_term;

  // Prescaler: only exists when more than one enabled cycle per step is needed.
  generate
    if (PRESCALE == 1) begin : g_no_presc
      assign w_step = bus.CE;
    end else begin : g_presc
      localparam int              PW     = $clog2(PRESCALE);
      localparam logic [PW-1:0]   P_LAST = PW'(PRESCALE - 1);
      localparam logic [PW-1:0]   P_ONE  = {{(PW-1){1'b0}}, 1'b1};

      logic [PW-1:0] r_p;
      logic          w_p_last;

      assign w_p_last = (r_p == P_LAST);
      assign w_step   = bus.CE & w_p_last;

      // Count enabled cycles; clear and load both restart the step interval.
      always_ff @(posedge CLK or negedge R_N) begin
        if (!R_N) begin
          r_p <= '0;
        end else if (bus.CLR || bus.LD) begin
          r_p <= '0;
        end else if (bus.CE) begin
          if (w_p_last) begin
            r_p <= '0;
          end else begin
            r_p <= r_p + P_ONE;
          end
        end
      end
    end
  endgenerate

  // Next count and terminal detection for a step; LIMIT is only looked at here.
  always_comb begin
    w_q_next = r_q;
    w_term   = 1'b0;
    if (w_step) begin
      if (bus.UP) begin
        if (r_q >= bus.LIMIT) begin
          // Also covers a loaded value above LIMIT: that step is terminal.
          w_term   = 1'b1;
          w_q_next = SATURATE ? bus.LIMIT : ZERO;
        end else begin
          w_q_next = r_q + ONE;
        end
      end else begin
        if (r_q == ZERO) begin
          w_term   = 1'b1;
          w_q_next = SATURATE ? ZERO : bus.LIMIT;
        end else if (r_q > bus.LIMIT) begin
          // Out-of-range count snaps back into range without signalling.
          w_q_next = bus.LIMIT;
        end else begin
          w_q_next = r_q - ONE;
        end
      end
    end
  end

  // Count, terminal pulse and sticky overflow; clear beats load beats step.
  always_ff @(posedge CLK or negedge R_N) begin
    if (!R_N) begin
      r_q   <= '0;
      r_tc  <= 1'b0;
      r_ovf <= 1'b0;
    end else if (bus.CLR) begin
      r_q   <= '0;
      r_tc  <= 1'b0;
      r_ovf <= 1'b0;
    end else if (bus.LD) begin
      r_q   <= bus.D;
      r_tc  <= 1'b0;
    end else begin
      r_q   <= w_q_next;
      r_tc  <= w_term;
      r_ovf <= r_ovf | w_term;
    end
  end

  assign bus.Q   = r_q;
  assign bus.TC  = r_tc;
  assign bus.OVF = r_ovf;
  assign bus.LED = r_q[WIDTH-1 -: NUM_LEDS];

endmodule

// File: tb/tb_counter_nb.sv
// Scoreboard bench for counter_nb: five instances with different parameter
// sets; directed stimulus pushes hand-computed expectations, a monitor on the
// falling clock edge pops and compares them.
module tb_counter_nb;

  logic clk;
  logic rst_n;

  counter_nb_if #(.WIDTH(32), .NUM_LEDS(3)) ia ();
  counter_nb_if #(.WIDTH(8),  .NUM_LEDS(3)) ib ();
  counter_nb_if #(.WIDTH(8),  .NUM_LEDS(3)) ic ();
  counter_nb_if #(.WIDTH(8),  .NUM_LEDS(3)) id ();
  counter_nb_if #(.WIDTH(16), .NUM_LEDS(3)) ie ();

  counter_nb #(.WIDTH(32), .PRESCALE(1), .SATURATE(1'b0), .NUM_LEDS(3)) ua (.CLK(clk), .R_N(rst_n), .bus(ia));
  counter_nb #(.WIDTH(8),  .PRESCALE(1), .SATURATE(1'b0), .NUM_LEDS(3)) ub (.CLK(clk), .R_N(rst_n), .bus(ib));
  counter_nb #(.WIDTH(8),  .PRESCALE(4), .SATURATE(1'b0), .NUM_LEDS(3)) uc (.CLK(clk), .R_N(rst_n), .bus(ic));
  counter_nb #(.WIDTH(8),  .PRESCALE(1), .SATURATE(1'b1), .NUM_LEDS(3)) ud (.CLK(clk), .R_N(rst_n), .bus(id));
  counter_nb #(.WIDTH(16), .PRESCALE(1), .SATURATE(1'b0), .NUM_LEDS(3)) ue (.CLK(clk), .R_N(rst_n), .bus(ie));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          dut;   // 0..4 -> A..E
    int          kind;  // 0 Q, 1 TC, 2 OVF, 3 LED
    logic [63:0] val;
    string       name;
  } item_t;

  item_t sb[$];
  int    checks   = 0;
  int    failures = 0;

  task automatic expv(input int dut, input int kind, input logic [63:0] v, input string nm);
    item_t it;
    it.dut = dut; it.kind = kind; it.val = v; it.name = nm;
    sb.push_back(it);
  endtask

  task automatic exp3(input int dut, input logic [63:0] q, input logic tc, input logic ovf, input string nm);
    expv(dut, 0, q,          {nm, "_q"});
    expv(dut, 1, {63'd0, tc},  {nm, "_tc"});
    expv(dut, 2, {63'd0, ovf}, {nm, "_ovf"});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] actual(input int dut, input int kind);
    logic [63:0] q, tc, ovf, led;
    q = '0; tc = '0; ovf = '0; led = '0;
    case (dut)
      0: begin q = {32'd0, ia.Q}; tc[0] = ia.TC; ovf[0] = ia.OVF; led[2:0] = ia.LED; end
      1: begin q = {56'd0, ib.Q}; tc[0] = ib.TC; ovf[0] = ib.OVF; led[2:0] = ib.LED; end
      2: begin q = {56'd0, ic.Q}; tc[0] = ic.TC; ovf[0] = ic.OVF; led[2:0] = ic.LED; end
      3: begin q = {56'd0, id.Q}; tc[0] = id.TC; ovf[0] = id.OVF; led[2:0] = id.LED; end
      default: begin q = {48'd0, ie.Q}; tc[0] = ie.TC; ovf[0] = ie.OVF; led[2:0] = ie.LED; end
    endcase
    case (kind)
      0:       return q;
      1:       return tc;
      2:       return ovf;
      default: return led;
    endcase
  endfunction

  // Monitor: outputs are stable mid-cycle, so compare every pending expectation here.
  always @(negedge clk) begin
    item_t       it;
    logic [63:0] a;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      a  = actual(it.dut, it.kind);
      checks++;
      if (a !== it.val) begin
        failures++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", it.name, a, it.val);
      end
    end
  end

  int          ce_seq [7] = '{1, 1, 0, 0, 0, 1, 1};
  logic [63:0] qc_seq [7] = '{64'd5, 64'd5, 64'd5, 64'd5, 64'd5, 64'd5, 64'd6};

  initial begin
    rst_n = 1'b0;
    ia.CE = 0; ia.CLR = 0; ia.LD = 0; ia.D = '0; ia.UP = 1; ia.LIMIT = 32'hFFFF_FFFF;
    ib.CE = 0; ib.CLR = 0; ib.LD = 0; ib.D = '0; ib.UP = 1; ib.LIMIT = 8'd9;
    ic.CE = 0; ic.CLR = 0; ic.LD = 0; ic.D = '0; ic.UP = 1; ic.LIMIT = 8'd255;
    id.CE = 0; id.CLR = 0; id.LD = 0; id.D = '0; id.UP = 1; id.LIMIT = 8'd5;
    ie.CE = 0; ie.CLR = 0; ie.LD = 0; ie.D = '0; ie.UP = 1; ie.LIMIT = 16'd100;
    #1;
    exp3(0, 64'd0, 1'b0, 1'b0, "rst_A");
    expv(0, 3, 64'd0, "rst_A_led");
    @(negedge clk); #1;
    rst_n = 1'b1;

    // A: free count 1000 cycles then hold
    ia.CE = 1;
    repeat (1000) tick();
    ia.CE = 0;
    expv(0, 0, 64'd1000, "A_q1000");
    for (int i = 0; i < 5; i++) begin
      tick();
      expv(0, 0, 64'd1000, $sformatf("A_hold%0d", i));
    end
    exp3(0, 64'd1000, 1'b0, 1'b0, "A_end");
    expv(0, 3, 64'd0, "A_led");

    // B: wrap at 9, then reverse
    ib.CE = 1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp3(1, k, 1'b0, 1'b0, $sformatf("B_up%0d", k));
    end
    tick(); exp3(1, 64'd0, 1'b1, 1'b1, "B_wrap");
    tick(); exp3(1, 64'd1, 1'b0, 1'b1, "B_after");
    ib.UP = 0;
    tick(); exp3(1, 64'd0, 1'b0, 1'b1, "B_dn0");
    tick(); exp3(1, 64'd9, 1'b1, 1'b1, "B_dnwrap");
    tick(); exp3(1, 64'd8, 1'b0, 1'b1, "B_dn8");
    ib.CE = 0;

    // C: prescale by 4
    ic.CE = 1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      expv(2, 0, k / 4, $sformatf("C_pre%0d", k));
    end
    for (int k = 0; k < 7; k++) begin
      ic.CE = ce_seq[k][0];
      tick();
      expv(2, 0, qc_seq[k], $sformatf("C_gap%0d", k));
    end
    expv(2, 1, 64'd0, "C_tc");
    ic.CE = 0;

    // D: saturate at 5
    id.CE = 1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp3(3, (k > 5) ? 64'd5 : k, (k > 5), (k > 5), $sformatf("D_st%0d", k));
    end
    id.CE = 0; id.CLR = 1;
    tick(); exp3(3, 64'd0, 1'b0, 1'b0, "D_clr");
    id.CLR = 0;

    // E: load beyond limit, priority cases
    ie.CE = 1; ie.LD = 1; ie.D = 16'd200;
    tick(); exp3(4, 64'd200, 1'b0, 1'b0, "E_ld");
    ie.LD = 0;
    tick(); exp3(4, 64'd0, 1'b1, 1'b1, "E_upterm");
    ie.LD = 1;
    tick(); exp3(4, 64'd200, 1'b0, 1'b1, "E_ld2");
    ie.LD = 0; ie.UP = 0;
    tick(); exp3(4, 64'd100, 1'b0, 1'b1, "E_snap");
    ie.CE = 0; ie.CLR = 1; ie.LD = 1; ie.D = 16'd55;
    tick(); exp3(4, 64'd0, 1'b0, 1'b0, "E_clrld");
    ie.CLR = 0; ie.D = 16'd50;
    tick(); exp3(4, 64'd50, 1'b0, 1'b0, "E_ldnoce");
    ie.LD = 0;

    // A: terminal step, LED load, then async reset between edges
    ia.LD = 1; ia.D = 32'hFFFF_FFFF;
    tick(); expv(0, 3, 64'd7, "A_led_ff");
    ia.LD = 0; ia.CE = 1;
    tick(); exp3(0, 64'd0, 1'b1, 1'b1, "A_term");
    ia.CE = 0; ia.LD = 1; ia.D = 32'hE000_0000;
    tick(); exp3(0, 64'hE000_0000, 1'b0, 1'b1, "A_lde0");
    expv(0, 3, 64'd7, "A_led7");
    ia.LD = 0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    exp3(0, 64'd0, 1'b0, 1'b0, "A_async");
    expv(0, 3, 64'd0, "A_async_led");
    exp3(1, 64'd0, 1'b0, 1'b0, "B_async");
    @(negedge clk); #1;
    rst_n = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_nb.md
Name: counter_nb

Overview:
- Parametrised successor to the fixed 32-bit binary counter.
- Generic-width up/down counter with:
  - a built-in clock-enable prescaler
  - a programmable terminal value
  - wrap or saturate mode
  - synchronous clear and parallel load
  - a terminal-count pulse and a sticky overflow flag
- Sits in the divided-clock domain (after the clocking wizard) and drives the board LEDs from its top bits.

Parameters:
- WIDTH, 32: counter width in bits, 2..64.
- PRESCALE, 1: count step once every PRESCALE enabled cycles, 1..65536; 1 means a step on every CE cycle.
- SATURATE, 0: 0 means wrap at the terminal value; 1 means hold at the terminal value.
- NUM_LEDS, 3: number of LED outputs, 1..WIDTH; LEDs are driven from the top bits of Q.

Ports:
- CLK, input, 1: counter clock (divided clock from the clocking wizard).
- R_N, input, 1: asynchronous active-low reset.
- CE, input, 1: count enable; gates the prescaler and the counter.
- CLR, input, 1: synchronous clear of Q, the prescaler and OVF.
- LD, input, 1: synchronous parallel load of D into Q.
- D, input, WIDTH: load value.
- UP, input, 1: direction; 1 counts up, 0 counts down.
- LIMIT, input, WIDTH: terminal value; the count range is 0..LIMIT.
- Q, output, WIDTH: current count (registered).
- TC, output, 1: registered one-cycle pulse on each terminal step.
- OVF, output, 1: sticky; set on any terminal step.
- LED, output, NUM_LEDS: equals Q[WIDTH-1 : WIDTH-NUM_LEDS] (combinational from Q).

Behaviour:
- Reset (R_N=0, asynchronous, takes effect immediately):
  - Q=0, prescaler=0, TC=0, OVF=0, and therefore LED=0.
  - Release is sampled on the next CLK rising edge.
- Priority on each rising edge is CLR > LD > step. CE gates the step and the prescaler only; CLR and LD act regardless of CE.
- CLR:
  - Q=0, prescaler=0, OVF=0, TC=0.
- LD:
  - Q=D, prescaler=0, TC=0; OVF is unchanged.
  - D>LIMIT is accepted as-is.
- Prescaler:
  - Internal counter P of width clog2(PRESCALE), omitted when PRESCALE=1.
  - With CE=1: P increments; when P==PRESCALE-1, a step occurs and P returns to 0.
  - With CE=0: P holds.
  - Internal step strobe S = CE & (P==PRESCALE-1).
- Step (S=1), up (UP=1):
  - Q>=LIMIT: terminal step. Q becomes 0 when SATURATE=0, or LIMIT when SATURATE=1.
  - Otherwise Q becomes Q+1.
- Step (S=1), down (UP=0):
  - Q==0: terminal step. Q becomes LIMIT when SATURATE=0, or 0 when SATURATE=1.
  - Q>LIMIT: Q becomes LIMIT (non-terminal).
  - Otherwise Q becomes Q-1.
- Terminal step:
  - TC=1 for exactly the cycle in which the new Q is visible; TC=0 otherwise.
  - OVF is set to 1 and held until CLR or reset.
- Saturate mode: TC pulses on every step while the count sits at the boundary (one pulse per prescaled step).
- LIMIT=0:
  - Up: every step is terminal; Q stays 0 in both modes.
  - Down: same, Q stays 0.
- UP may change on any cycle and takes effect on the next step; there is no hidden state beyond P.
- LIMIT is sampled only at step time; changing it mid-count is legal.
- Latency: a CE-qualified edge updates Q at that edge (registered); the first step occurs PRESCALE enabled cycles after CE rises with P=0.
- Reset mid-count clears everything asynchronously; no pending TC survives.

Test Plan:
- WIDTH=32, PRESCALE=1, LIMIT=0xFFFFFFFF: release R_N, CE=1 for 1000 cycles, then hold CE=0 for 5 cycles -> Q=1000 (0x3E8) and constant while CE=0; TC=0; OVF=0; LED=0.
- WIDTH=8, LIMIT=9, SATURATE=0, UP=1, CE=1:
  - Q sequence is 0..9, 0, 1.
  - TC is high only in the cycle where Q returns to 0; OVF=1 from then on.
  - Switch to UP=0 at Q=1 -> Q goes 0 then 9, with a second TC pulse.
- WIDTH=8, PRESCALE=4, LIMIT=255: CE=1 for 20 cycles -> Q=5; each step lands exactly 4 cycles apart; toggling CE low for 3 cycles delays the next step by 3 cycles.
- SATURATE=1, LIMIT=5, UP=1: run 10 steps -> Q holds at 5 from step 5 onward, with a TC pulse on each of steps 6..10. Then CLR -> Q=0, OVF=0.
- WIDTH=16, LIMIT=100:
  - LD with D=200 and CE=1 on the same edge -> Q=200, no step. Next step (up) -> Q=0 with TC=1.
  - LD with D=200, then UP=0 -> Q=100 with no TC.
  - CLR and LD on the same edge -> Q=0.
- Mid-count async reset: WIDTH=32, NUM_LEDS=3, LD with D=0xE0000000 -> LED=3'b111. Pulse R_N low between clock edges -> Q, LED, TC and OVF are 0 immediately, before the next CLK edge.
